// File: rtl/mine_field_engine.sv
// mine_field_engine: ROWS x COLS minesweeper board with neighbour counting, flood-fill reveal and a registered read port
module mine_field_engine #(
  parameter int ROWS = 5,
  parameter int COLS = 5,
  parameter int ADDR_W = 5,
  parameter int CNT_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              load_mine,
  input  logic              start_count,
  input  logic              reveal_req,
  input  logic [ADDR_W-1:0] reveal_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_mine,
  output logic [CNT_W-1:0]  rd_count,
  output logic              rd_revealed,
  output logic              busy,
  output logic              done,
  output logic              hit_mine,
  output logic [ADDR_W:0]   revealed_total
);
  localparam int N = ROWS * COLS;
  localparam int M = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] NW = (ADDR_W + 1)'(N);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);
  if (N > M) begin : g_bad_size
    $error("mine_field_engine: ROWS*COLS exceeds 2**ADDR_W");
  end
  typedef enum logic [2:0] {IDLE, COUNT, SEED, SWEEP, SWEEP_END, DONE} state_t;
  state_t state, next;
  logic [M-1:0] mine, rev, nbr_zero;
  logic [CNT_W-1:0] cnt [M];
  logic [CNT_W-1:0] nbr_cnt [M];
  logic [ADDR_W-1:0] idx;
  logic changed, idx_ok, rd_ok, load_ok, seed_new, sweep_rev;
  // Storage is padded to 2**ADDR_W so any address indexes legally; cells >= N stay zero.
  for (genvar i = 0; i < M; i++) begin : g_cell
    logic [8:0] nm, nz;
    for (genvar k = 0; k < 9; k++) begin : g_nb
      localparam int R = i / COLS + k / 3 - 1;
      localparam int C = i % COLS + k % 3 - 1;
      if (i < N && k != 4 && R >= 0 && R < ROWS && C >= 0 && C < COLS) begin : g_on
        assign nm[k] = mine[R*COLS+C];
        assign nz[k] = rev[R*COLS+C] && cnt[R*COLS+C] == '0;
      end else begin : g_off
        assign nm[k] = 1'b0;
        assign nz[k] = 1'b0;
      end
    end
    assign nbr_cnt[i] = CNT_W'($countones(nm));
    assign nbr_zero[i] = |nz;
  end
  assign idx_ok = {1'b0, idx} < NW;
  assign rd_ok = {1'b0, rd_addr} < NW;
  assign load_ok = {1'b0, load_addr} < NW;
  assign seed_new = idx_ok && !rev[idx];
  assign sweep_rev = !rev[idx] && !mine[idx] && nbr_zero[idx];
  assign busy = state inside {COUNT, SEED, SWEEP, SWEEP_END};
  assign done = state == DONE;
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      IDLE:      next = clear || load_en ? IDLE : start_count ? COUNT : reveal_req ? SEED : IDLE;
      COUNT:     next = idx == LAST ? DONE : COUNT;
      SEED:      next = seed_new && !mine[idx] && cnt[idx] == '0 ? SWEEP : DONE;
      SWEEP:     next = idx == LAST ? SWEEP_END : SWEEP;
      SWEEP_END: next = changed ? SWEEP : DONE;
      default:   next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      mine <= '0;
      rev <= '0;
      for (int j = 0; j < M; j++) cnt[j] <= '0;
      idx <= '0;
      changed <= 1'b0;
      hit_mine <= 1'b0;
      revealed_total <= '0;
      rd_mine <= 1'b0;
      rd_count <= '0;
      rd_revealed <= 1'b0;
    end else begin
      rd_mine <= rd_ok && mine[rd_addr];
      rd_count <= rd_ok ? cnt[rd_addr] : '0;
      rd_revealed <= rd_ok && rev[rd_addr];
      case (state)
        IDLE: begin
          if (clear) begin
            rev <= '0;
            hit_mine <= 1'b0;
            revealed_total <= '0;
          end else if (load_en) begin
            if (load_ok) mine[load_addr] <= load_mine;
          end else if (start_count) idx <= '0;
          else if (reveal_req) idx <= reveal_addr;
        end
        COUNT: begin
          cnt[idx] <= nbr_cnt[idx];
          idx <= idx + 1'b1;
        end
        SEED: begin
          if (seed_new) begin
            rev[idx] <= 1'b1;
            revealed_total <= revealed_total + 1'b1;
            hit_mine <= hit_mine | mine[idx];
          end
          idx <= '0;
          changed <= 1'b0;
        end
        SWEEP: begin
          if (sweep_rev) begin
            rev[idx] <= 1'b1;
            revealed_total <= revealed_total + 1'b1;
            changed <= 1'b1;
          end
          idx <= idx + 1'b1;
        end
        SWEEP_END: begin
          changed <= 1'b0;
          idx <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mine_field_engine.sv
// tb_mine_field_engine: randomized and directed checks of a 5x5 and a 3x7 board against a queue-based flood-fill model
module tb_mine_field_engine;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic reset, clear, load_en, load_mine, start_count, reveal_req, sel;
  logic [4:0] load_addr, reveal_addr, rd_addr;
  logic rd_mine_v [2];
  logic [3:0] rd_count_v [2];
  logic rd_rev_v [2];
  logic busy_v [2];
  logic done_v [2];
  logic hit_v [2];
  logic [5:0] total_v [2];
  int checks = 0, errors = 0;
  int rows, cols, n;
  bit mm [32];
  int mc [32];
  bit mr [32];
  int mtot;
  bit mhit;

  mine_field_engine #(.ROWS(5), .COLS(5), .ADDR_W(5), .CNT_W(4)) dut0 (
    .clock(clock), .reset(reset), .clear(clear && !sel), .load_en(load_en && !sel),
    .load_addr(load_addr), .load_mine(load_mine), .start_count(start_count && !sel),
    .reveal_req(reveal_req && !sel), .reveal_addr(reveal_addr), .rd_addr(rd_addr),
    .rd_mine(rd_mine_v[0]), .rd_count(rd_count_v[0]), .rd_revealed(rd_rev_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .hit_mine(hit_v[0]), .revealed_total(total_v[0]));

  mine_field_engine #(.ROWS(3), .COLS(7), .ADDR_W(5), .CNT_W(4)) dut1 (
    .clock(clock), .reset(reset), .clear(clear && sel), .load_en(load_en && sel),
    .load_addr(load_addr), .load_mine(load_mine), .start_count(start_count && sel),
    .reveal_req(reveal_req && sel), .reveal_addr(reveal_addr), .rd_addr(rd_addr),
    .rd_mine(rd_mine_v[1]), .rd_count(rd_count_v[1]), .rd_revealed(rd_rev_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .hit_mine(hit_v[1]), .revealed_total(total_v[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit is_nb(int a, int b);
    int dr = a / cols - b / cols;
    int dc = a % cols - b % cols;
    return a != b && dr >= -1 && dr <= 1 && dc >= -1 && dc <= 1;
  endfunction

  function automatic void m_reset();
    for (int a = 0; a < 32; a++) begin
      mm[a] = 0;
      mc[a] = 0;
      mr[a] = 0;
    end
    mtot = 0;
    mhit = 0;
  endfunction

  function automatic void m_count();
    for (int a = 0; a < n; a++) begin
      mc[a] = 0;
      for (int b = 0; b < n; b++) if (is_nb(a, b) && mm[b]) mc[a]++;
    end
  endfunction

  // Flood is a breadth-first closure over every revealed zero cell.
  function automatic void m_reveal(int a, output bit flood);
    int q [$];
    flood = 0;
    if (a >= n || mr[a]) return;
    mr[a] = 1;
    mtot++;
    if (mm[a]) begin
      mhit = 1;
      return;
    end
    if (mc[a] != 0) return;
    flood = 1;
    for (int i = 0; i < n; i++) if (mr[i] && mc[i] == 0) q.push_back(i);
    while (q.size() > 0) begin
      int x = q.pop_front();
      for (int b = 0; b < n; b++)
        if (is_nb(x, b) && !mr[b] && !mm[b]) begin
          mr[b] = 1;
          mtot++;
          if (mc[b] == 0) q.push_back(b);
        end
    end
  endfunction

  task automatic wait_done(input int k0, output int k);
    k = k0;
    while (!done_v[sel] && k < 3000) begin
      @(negedge clock);
      k++;
    end
    if (!done_v[sel]) check("done timeout", 0, 1);
  endtask

  task automatic do_load(input int a, input bit m);
    @(negedge clock);
    load_en = 1;
    load_addr = a[4:0];
    load_mine = m;
    @(negedge clock);
    load_en = 0;
    if (a < n) mm[a] = m;
  endtask

  task automatic do_clear();
    @(negedge clock);
    clear = 1;
    @(negedge clock);
    clear = 0;
    for (int a = 0; a < 32; a++) mr[a] = 0;
    mtot = 0;
    mhit = 0;
  endtask

  task automatic do_count(input string tag);
    int k;
    @(negedge clock);
    start_count = 1;
    @(negedge clock);
    start_count = 0;
    wait_done(1, k);
    check({tag, " count latency"}, k, n + 1);
    m_count();
  endtask

  task automatic do_reveal(input string tag, input int a);
    int k;
    bit flood;
    @(negedge clock);
    reveal_req = 1;
    reveal_addr = a[4:0];
    @(negedge clock);
    reveal_req = 0;
    wait_done(1, k);
    m_reveal(a, flood);
    if (!flood) check({tag, " reveal latency"}, k, 2);
    check({tag, " hit_mine"}, hit_v[sel], mhit);
    check({tag, " revealed_total"}, total_v[sel], mtot);
  endtask

  task automatic read_cell(input int a, output logic m, output logic [3:0] c, output logic r);
    @(negedge clock);
    rd_addr = a[4:0];
    @(negedge clock);
    m = rd_mine_v[sel];
    c = rd_count_v[sel];
    r = rd_rev_v[sel];
  endtask

  task automatic expect_cnt(input string tag, input int a, input int exp);
    logic m, r;
    logic [3:0] c;
    read_cell(a, m, c, r);
    check($sformatf("%s count[%0d]", tag, a), c, exp);
  endtask

  task automatic check_board(input string tag);
    logic m, r;
    logic [3:0] c;
    for (int a = 0; a < 32; a++) begin
      read_cell(a, m, c, r);
      check($sformatf("%s mine[%0d]", tag, a), m, mm[a]);
      check($sformatf("%s count[%0d]", tag, a), c, mc[a]);
      check($sformatf("%s revealed[%0d]", tag, a), r, mr[a]);
    end
  endtask

  initial begin
    int k;
    {clear, load_en, load_mine, start_count, reveal_req, sel} = '0;
    {load_addr, reveal_addr, rd_addr} = '0;
    rows = 5;
    cols = 5;
    n = 25;
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    m_reset();
    check("reset busy", busy_v[0], 0);
    check("reset done", done_v[0], 0);
    check("reset hit_mine", hit_v[0], 0);
    check("reset total", total_v[0], 0);
    check_board("reset");
    do_load(12, 1);
    do_count("centre");
    expect_cnt("centre", 6, 1);
    expect_cnt("centre", 18, 1);
    expect_cnt("centre", 12, 0);
    check_board("centre");
    do_load(12, 0);
    do_load(0, 1);
    do_load(1, 1);
    do_load(5, 1);
    do_count("corner3");
    expect_cnt("corner3", 6, 3);
    expect_cnt("corner3", 2, 1);
    expect_cnt("corner3", 10, 1);
    expect_cnt("corner3", 0, 2);
    expect_cnt("corner3", 24, 0);
    do_load(1, 0);
    do_load(5, 0);
    do_count("flood");
    do_reveal("flood", 24);
    check("flood total const", total_v[0], 24);
    check("flood hit const", hit_v[0], 0);
    check_board("flood");
    do_reveal("again", 24);
    do_clear();
    @(negedge clock);
    reveal_req = 1;
    reveal_addr = 5'd0;
    @(negedge clock);
    reveal_req = 0;
    wait_done(1, k);
    check("mine reveal latency", k, 2);
    check("mine reveal hit", hit_v[0], 1);
    check("mine reveal total", total_v[0], 1);
    do_clear();
    check("clear hit", hit_v[0], 0);
    check("clear total", total_v[0], 0);
    do_load(27, 1);
    do_reveal("oob", 29);
    check_board("oob");
    @(negedge clock);
    reveal_req = 1;
    reveal_addr = 5'd24;
    @(negedge clock);
    reveal_req = 0;
    repeat (4) @(negedge clock);
    check("mid sweep busy", busy_v[0], 1);
    reset = 1;
    @(negedge clock);
    reset = 0;
    m_reset();
    check("post reset busy", busy_v[0], 0);
    check("post reset total", total_v[0], 0);
    check("post reset rd_mine", rd_mine_v[0], 0);
    check("post reset rd_count", rd_count_v[0], 0);
    check_board("post reset");
    do_load(12, 1);
    do_count("post reset");
    check_board("post reset count");
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < n; a++) do_load(a, $urandom_range(0, 99) < 15);
      do_count($sformatf("rand%0d", it));
      do_clear();
      for (int r = 0; r < 4; r++)
        do_reveal($sformatf("rand%0d.%0d", it, r), $urandom_range(0, 7) == 0 ? $urandom_range(0, 31) : $urandom_range(0, n - 1));
      check_board($sformatf("rand%0d", it));
    end
    reset = 1;
    @(negedge clock);
    reset = 0;
    sel = 1;
    rows = 3;
    cols = 7;
    n = 21;
    m_reset();
    do_load(20, 1);
    do_count("3x7");
    expect_cnt("3x7", 13, 1);
    expect_cnt("3x7", 19, 1);
    expect_cnt("3x7", 12, 1);
    do_reveal("3x7", 0);
    check("3x7 total const", total_v[1], 20);
    check_board("3x7");
    @(negedge clock);
    start_count = 1;
    @(negedge clock);
    start_count = 0;
    load_en = 1;
    load_addr = 5'd0;
    load_mine = 1;
    start_count = 1;
    @(negedge clock);
    load_en = 0;
    start_count = 0;
    wait_done(2, k);
    check("busy ignore latency", k, n + 1);
    repeat (3) @(negedge clock);
    check("busy ignore idle", busy_v[1], 0);
    check("busy ignore no done", done_v[1], 0);
    check_board("busy ignore");
    for (int it = 0; it < 3; it++) begin
      for (int a = 0; a < n; a++) do_load(a, $urandom_range(0, 99) < 12);
      do_count($sformatf("r37_%0d", it));
      do_clear();
      for (int r = 0; r < 3; r++) do_reveal($sformatf("r37_%0d.%0d", it, r), $urandom_range(0, 23));
      check_board($sformatf("r37_%0d", it));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
